// File: rtl/tx_arq_ctrl.sv
`default_nettype none
// ============================================================================
// tx_arq_ctrl : transmit-side ARQ sequencer (frame start, ack decode, retry/drop)
// Rev 1.0
// ============================================================================
module tx_arq_ctrl #(
    parameter int MAX_RETRIES    = 3,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16,
    parameter int RTRY_W         = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_arq_en,
    input  logic              i_frame_req,
    input  logic              i_frame_done,
    input  logic              i_otn_rx_ack,
    output logic              o_frame_start,
    output logic              o_frame_commit,
    output logic              o_frame_drop,
    output logic              o_timeout,
    output logic              o_nak,
    output logic [RTRY_W-1:0] o_retry_count,
    output logic              o_busy
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_START    = 4'd1,
        S_SEND     = 4'd2,
        S_WAIT_ACK = 4'd3,
        S_ACK_DATA = 4'd4,
        S_ACK_STOP = 4'd5,
        S_FAIL     = 4'd6,
        S_COMMIT   = 4'd7,
        S_DROP     = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0]  C_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTRY_W-1:0] C_MAX_RTRY = RTRY_W'(MAX_RETRIES);

    state_t            state_q, state_d;
    logic              ack_meta_q, ack_meta_d;
    logic              ack_s_q, ack_s_d;
    logic              arq_en_q, arq_en_d;
    logic              ack_bit_q, ack_bit_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [RTRY_W-1:0] retry_q, retry_d;
    logic              timeout_q, timeout_d;
    logic              nak_q, nak_d;

    always_comb begin
        state_d    = state_q;
        ack_meta_d = i_otn_rx_ack;
        ack_s_d    = ack_meta_q;
        arq_en_d   = arq_en_q;
        ack_bit_d  = ack_bit_q;
        tmo_cnt_d  = '0;
        retry_d    = retry_q;
        timeout_d  = 1'b0;
        nak_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_frame_req) state_d = S_START;
            end
            S_START: begin
                arq_en_d = i_arq_en;
                state_d  = S_SEND;
            end
            S_SEND: begin
                if (i_frame_done) state_d = arq_en_q ? S_WAIT_ACK : S_COMMIT;
            end
            S_WAIT_ACK: begin
                // A start bit on the final wait cycle still counts as an ack.
                if (!ack_s_q) begin
                    state_d = S_ACK_DATA;
                end else if (tmo_cnt_q == C_TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_FAIL;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            S_ACK_DATA: begin
                ack_bit_d = ack_s_q;
                state_d   = S_ACK_STOP;
            end
            S_ACK_STOP: begin
                if (!ack_s_q && ack_bit_q) begin
                    state_d = S_COMMIT;
                end else begin
                    nak_d   = 1'b1;
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                if (retry_q == C_MAX_RTRY) begin
                    state_d = S_DROP;
                end else begin
                    retry_d = retry_q + RTRY_W'(1);
                    state_d = S_START;
                end
            end
            S_COMMIT, S_DROP: begin
                retry_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ack synchronizer idles high so reset looks like an idle line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            ack_meta_q <= 1'b1;
            ack_s_q    <= 1'b1;
            arq_en_q   <= 1'b0;
            ack_bit_q  <= 1'b0;
            tmo_cnt_q  <= '0;
            retry_q    <= '0;
            timeout_q  <= 1'b0;
            nak_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
            arq_en_q   <= arq_en_d;
            ack_bit_q  <= ack_bit_d;
            tmo_cnt_q  <= tmo_cnt_d;
            retry_q    <= retry_d;
            timeout_q  <= timeout_d;
            nak_q      <= nak_d;
        end
    end

    assign o_frame_start  = (state_q == S_START);
    assign o_frame_commit = (state_q == S_COMMIT);
    assign o_frame_drop   = (state_q == S_DROP);
    assign o_timeout      = timeout_q;
    assign o_nak          = nak_q;
    assign o_retry_count  = retry_q;
    assign o_busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/tx_arq_ctrl.md
Name: tx_arq_ctrl

Overview:
- Transmit-side ARQ sequencer for the OTN link. Sits between the TX frame buffer/serializer and the serial ack line driven by the far-end receiver.
- Starts each frame transmission and, when ARQ is enabled, waits for the receiver's 3-bit ack word.
- On a good ack it releases the frame. On a bad ack or timeout it re-sends the frame, up to a retry limit. At the limit it drops the frame.

Parameters:
- MAX_RETRIES, 3: re-sends allowed after the first transmission before the frame is dropped.
- TIMEOUT_CYCLES, 65535: i_clk cycles spent in WAIT_ACK before a timeout is declared.
- CNT_W, 16: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- RTRY_W, 2: width of o_retry_count. Must satisfy 2^RTRY_W > MAX_RETRIES.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_arq_en  in  1  ARQ enable; sampled once per frame in START
- i_frame_req  in  1  TX buffer holds a complete frame
- i_frame_done  in  1  serializer has shifted out the last frame byte (1-cycle pulse)
- i_otn_rx_ack  in  1  serial ack line from the receiver; idles high
- o_frame_start  out  1  1-cycle pulse: serializer sends the buffered frame from byte 0
- o_frame_commit  out  1  1-cycle pulse: frame delivered, buffer may free it
- o_frame_drop  out  1  1-cycle pulse: retries exhausted, buffer frees the frame
- o_timeout  out  1  1-cycle pulse on each ack timeout
- o_nak  out  1  1-cycle pulse on each bad or malformed ack
- o_retry_count  out  RTRY_W  re-sends so far for the current frame
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE; all pulse outputs 0; o_busy 0; o_retry_count 0; timeout counter 0.
  - Both stages of the ack synchronizer reset to 1.
  - Asserting reset mid-frame aborts immediately. There is no commit or drop pulse.
- Ack input: passes through a 2-flop synchronizer, giving ack_s with 2 cycles of latency. Each ack bit lasts exactly one i_clk cycle. The word is: start 0, data bit (1 = good, 0 = bad), stop 0, then idle 1.
- State machine:
  - IDLE: if i_frame_req, go to START.
  - START: o_frame_start = 1 (Moore output). Latch arq_en_r <= i_arq_en. Go to SEND.
  - SEND: wait for i_frame_done. If arq_en_r, go to WAIT_ACK; otherwise go to COMMIT.
  - WAIT_ACK: the timeout counter increments each cycle.
    - If ack_s == 0, go to ACK_DATA and clear the counter.
    - Otherwise, if counter == TIMEOUT_CYCLES-1, pulse o_timeout and go to FAIL.
    - If both conditions occur in the same cycle, the start bit wins.
  - ACK_DATA: capture ack_bit <= ack_s. Go to ACK_STOP.
  - ACK_STOP: if ack_s == 0 and ack_bit == 1, go to COMMIT. Otherwise pulse o_nak and go to FAIL. A stop bit of 1 is a framing error and is treated as a bad ack.
  - FAIL: if o_retry_count == MAX_RETRIES, go to DROP. Otherwise increment o_retry_count and go to START (re-send).
  - COMMIT: o_frame_commit = 1; clear o_retry_count; go to IDLE.
  - DROP: o_frame_drop = 1; clear o_retry_count; go to IDLE.
- Latency:
  - i_frame_req high in IDLE to o_frame_start: 1 cycle.
  - Last ack bit (stop) at ack_s to o_frame_commit: 1 cycle.
- Ignored events:
  - i_frame_done outside SEND.
  - ack_s == 0 outside WAIT_ACK. Stray ack words while sending are discarded.
  - i_frame_req while busy.
- i_arq_en toggling mid-frame has no effect until the next START.
- At most MAX_RETRIES+1 transmissions per frame. o_retry_count never exceeds MAX_RETRIES.
- Back-to-back frames: after COMMIT or DROP, one IDLE cycle always precedes the next START.

Test Plan:
- i_arq_en=0, i_frame_req=1, i_frame_done pulsed 10 cycles after o_frame_start -> o_frame_commit exactly 1 cycle after SEND exits; no ack wait; o_retry_count stays 0.
- i_arq_en=1; after done, drive ack 1,0,1,0,1 -> one o_frame_commit; o_nak=0; o_retry_count=0.
- MAX_RETRIES=3; ack data bit 0 on every attempt -> 4 o_frame_start pulses, 3 o_nak plus 1 final o_nak, o_retry_count reaching 3, then one o_frame_drop.
- TIMEOUT_CYCLES=100; no ack after the first send -> o_timeout 100 cycles after WAIT_ACK entry; re-send; good ack on the 2nd attempt -> commit; o_retry_count returns to 0.
- Malformed ack 0,1,1 (stop bit high) -> o_nak and a re-send. Separately, ack start bit arriving on the exact timeout cycle -> decoded as an ack, with no o_timeout.
- Async i_rst_n low during WAIT_ACK -> all outputs 0 immediately (o_busy 0). After release with i_frame_req=1 -> o_frame_start 1 cycle later; i_arq_en toggled during SEND -> ignored for that frame.
